// File: rtl/pipe_pkg.sv
// Shared pipeline types for the memory-access stage: widths, FSM states and
// the MEM/WB payload carried into writeback.
package pipe_pkg;

   localparam int XLEN   = 32;
   localparam int REG_AW = 5;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } mem_state_t;

   typedef struct packed {
      logic [REG_AW-1:0] rd;
      logic              regwrite;
      logic [XLEN-1:0]   wbdata;
   } mem_wb_t;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register. A load captures the full payload; a bubble only
// kills the writeback enable so rd/data hold their previous values.
module mem_wb_reg
   import pipe_pkg::*;
(
   input  logic    clk_i,
   input  logic    start_i,
   input  logic    load,
   input  logic    bubble,
   input  mem_wb_t d,
   output mem_wb_t q
);

   // NOTE: clocked state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk_i) begin
      if (!start_i) begin
         q <= '0;
      end else if (load) begin
         q <= d;
      end else if (bubble) begin
         q.regwrite <= 1'b0;
      end
   end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: drives a req/ack data memory, stalls upstream while an
// access is outstanding and flags a hung memory with a sticky timeout.
module mem_stage
   import pipe_pkg::*;
#(
   parameter int XLEN     = pipe_pkg::XLEN,
   parameter int REG_AW   = pipe_pkg::REG_AW,
   parameter int MAX_WAIT = 16
) (
   input  logic              clk_i,
   input  logic              start_i,
   input  logic [REG_AW-1:0] RDaddr_i,
   input  logic [XLEN-1:0]   RS2data_i,
   input  logic [XLEN-1:0]   ALUResult_i,
   input  logic              MemRead_i,
   input  logic              MemWrite_i,
   input  logic              RegWrite_i,
   input  logic              MemtoReg_i,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [XLEN-1:0]   mem_addr_o,
   output logic [XLEN-1:0]   mem_wdata_o,
   input  logic              mem_ack_i,
   input  logic [XLEN-1:0]   mem_rdata_i,
   output logic              stall_o,
   output logic [REG_AW-1:0] RDaddr_o,
   output logic              RegWrite_o,
   output logic [XLEN-1:0]   WBdata_o,
   output logic              err_o
);

   localparam int CNT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((MAX_WAIT > 0) ? MAX_WAIT - 1 : 0);
   localparam logic [CNT_W-1:0] CNT_SAT  = '1;

   mem_state_t       state, state_nxt;
   logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;
   logic             acc;
   logic             set_err;
   logic             wb_load;
   logic             wb_bubble;
   mem_wb_t          wb_d;
   mem_wb_t          wb_q;

   assign acc         = MemRead_i | MemWrite_i;
   assign mem_addr_o  = ALUResult_i;
   assign mem_wdata_o = RS2data_i;

   // NOTE: every output of this block gets a default first, so no path can
   // leave a signal unassigned and infer a latch.
   always_comb begin
      state_nxt    = state;
      wait_cnt_nxt = wait_cnt;
      mem_req_o    = 1'b0;
      mem_we_o     = 1'b0;
      stall_o      = 1'b0;
      set_err      = 1'b0;
      wb_load      = 1'b0;
      wb_bubble    = 1'b0;
      wb_d.rd       = RDaddr_i;
      wb_d.regwrite = RegWrite_i;
      wb_d.wbdata   = ALUResult_i;

      unique case (state)
         IDLE: begin
            if (acc) begin
               stall_o      = 1'b1;
               wb_bubble    = 1'b1;
               state_nxt    = WAIT;
               wait_cnt_nxt = '0;
            end else begin
               wb_load = 1'b1;
            end
         end
         WAIT: begin
            mem_req_o = 1'b1;
            mem_we_o  = MemWrite_i;
            if (mem_ack_i) begin
               // A combined read+write is treated as a store; rdata is ignored.
               wb_load = 1'b1;
               if (MemtoReg_i && !MemWrite_i) wb_d.wbdata = mem_rdata_i;
               state_nxt = IDLE;
            end else if ((MAX_WAIT != 0) && (wait_cnt == CNT_LAST)) begin
               set_err   = 1'b1;
               wb_bubble = 1'b1;
               state_nxt = IDLE;
            end else begin
               stall_o   = 1'b1;
               wb_bubble = 1'b1;
               if (wait_cnt != CNT_SAT) wait_cnt_nxt = wait_cnt + 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase

      if (!start_i) begin
         mem_req_o = 1'b0;
         mem_we_o  = 1'b0;
         stall_o   = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!start_i) begin
         state    <= IDLE;
         wait_cnt <= '0;
         err_o    <= 1'b0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
         if (set_err) err_o <= 1'b1;
      end
   end

   mem_wb_reg u_mem_wb_reg (
      .clk_i   (clk_i),
      .start_i (start_i),
      .load    (wb_load),
      .bubble  (wb_bubble),
      .d       (wb_d),
      .q       (wb_q)
   );

   assign RDaddr_o   = wb_q.rd;
   assign RegWrite_o = wb_q.regwrite;
   assign WBdata_o   = wb_q.wbdata;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage (MAX_WAIT = 4): inputs change 1 ns after the
// rising edge, combinational outputs are sampled on the falling edge.
module tb_mem_stage;

   logic        clk_i = 1'b0;
   logic        start_i;
   logic [4:0]  RDaddr_i;
   logic [31:0] RS2data_i;
   logic [31:0] ALUResult_i;
   logic        MemRead_i;
   logic        MemWrite_i;
   logic        RegWrite_i;
   logic        MemtoReg_i;
   logic        mem_req_o;
   logic        mem_we_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic        mem_ack_i;
   logic [31:0] mem_rdata_i;
   logic        stall_o;
   logic [4:0]  RDaddr_o;
   logic        RegWrite_o;
   logic [31:0] WBdata_o;
   logic        err_o;

   int total = 0;
   int bad   = 0;

   always #5 clk_i = ~clk_i;

   mem_stage #(.MAX_WAIT(4)) dut (
      .clk_i       (clk_i),
      .start_i     (start_i),
      .RDaddr_i    (RDaddr_i),
      .RS2data_i   (RS2data_i),
      .ALUResult_i (ALUResult_i),
      .MemRead_i   (MemRead_i),
      .MemWrite_i  (MemWrite_i),
      .RegWrite_i  (RegWrite_i),
      .MemtoReg_i  (MemtoReg_i),
      .mem_req_o   (mem_req_o),
      .mem_we_o    (mem_we_o),
      .mem_addr_o  (mem_addr_o),
      .mem_wdata_o (mem_wdata_o),
      .mem_ack_i   (mem_ack_i),
      .mem_rdata_i (mem_rdata_i),
      .stall_o     (stall_o),
      .RDaddr_o    (RDaddr_o),
      .RegWrite_o  (RegWrite_o),
      .WBdata_o    (WBdata_o),
      .err_o       (err_o)
   );

   task automatic idle_inputs();
      RDaddr_i    = '0;
      RS2data_i   = '0;
      ALUResult_i = '0;
      MemRead_i   = 1'b0;
      MemWrite_i  = 1'b0;
      RegWrite_i  = 1'b0;
      MemtoReg_i  = 1'b0;
      mem_ack_i   = 1'b0;
      mem_rdata_i = '0;
   endtask

   task automatic next_edge();
      @(posedge clk_i);
      #1;
   endtask

   task automatic test_reset();
      start_i = 1'b0;
      idle_inputs();
      MemRead_i = 1'b1;
      @(negedge clk_i);
      total++; if (mem_req_o !== 1'b0) begin bad++; $display("FAIL rst_req got=%b want=0", mem_req_o); end
      total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL rst_stall got=%b want=0", stall_o); end
      next_edge();
      total++; if (RDaddr_o !== 5'd0) begin bad++; $display("FAIL rst_rd got=%0d want=0", RDaddr_o); end
      total++; if (RegWrite_o !== 1'b0) begin bad++; $display("FAIL rst_rw got=%b want=0", RegWrite_o); end
      total++; if (WBdata_o !== 32'h0) begin bad++; $display("FAIL rst_wb got=%h want=0", WBdata_o); end
      total++; if (err_o !== 1'b0) begin bad++; $display("FAIL rst_err got=%b want=0", err_o); end
      MemRead_i = 1'b0;
      start_i   = 1'b1;
   endtask

   task automatic test_alu();
      RDaddr_i = 5'd5; RegWrite_i = 1'b1; ALUResult_i = 32'h0000_00AA;
      @(negedge clk_i);
      total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL alu_stall got=%b want=0", stall_o); end
      total++; if (mem_req_o !== 1'b0) begin bad++; $display("FAIL alu_req got=%b want=0", mem_req_o); end
      next_edge();
      total++; if (RDaddr_o !== 5'd5) begin bad++; $display("FAIL alu_rd got=%0d want=5", RDaddr_o); end
      total++; if (RegWrite_o !== 1'b1) begin bad++; $display("FAIL alu_rw got=%b want=1", RegWrite_o); end
      total++; if (WBdata_o !== 32'hAA) begin bad++; $display("FAIL alu_wb got=%h want=000000aa", WBdata_o); end
      idle_inputs();
   endtask

   task automatic test_load();
      int nreq = 0;
      int nstall = 0;
      RDaddr_i = 5'd7; RegWrite_i = 1'b1; MemRead_i = 1'b1; MemtoReg_i = 1'b1;
      ALUResult_i = 32'h100; mem_rdata_i = 32'hDEAD_BEEF;
      for (int i = 0; i < 4; i++) begin
         mem_ack_i = (i == 3);
         @(negedge clk_i);
         if (mem_req_o) begin
            nreq++;
            total++; if (mem_addr_o !== 32'h100) begin bad++; $display("FAIL ld_addr got=%h want=00000100", mem_addr_o); end
            total++; if (mem_we_o !== 1'b0) begin bad++; $display("FAIL ld_we got=%b want=0", mem_we_o); end
         end
         if (stall_o) nstall++;
         next_edge();
         if (i < 3) begin
            total++; if (RegWrite_o !== 1'b0) begin bad++; $display("FAIL ld_bubble_rw cyc=%0d got=%b want=0", i, RegWrite_o); end
         end
      end
      total++; if (nreq != 3) begin bad++; $display("FAIL ld_req_cycles got=%0d want=3", nreq); end
      total++; if (nstall != 3) begin bad++; $display("FAIL ld_stall_cycles got=%0d want=3", nstall); end
      total++; if (RDaddr_o !== 5'd7) begin bad++; $display("FAIL ld_rd got=%0d want=7", RDaddr_o); end
      total++; if (RegWrite_o !== 1'b1) begin bad++; $display("FAIL ld_rw got=%b want=1", RegWrite_o); end
      total++; if (WBdata_o !== 32'hDEAD_BEEF) begin bad++; $display("FAIL ld_wb got=%h want=deadbeef", WBdata_o); end
      idle_inputs();
   endtask

   task automatic test_store();
      int nreq = 0;
      int nstall = 0;
      RDaddr_i = 5'd3; RegWrite_i = 1'b0; MemWrite_i = 1'b1;
      ALUResult_i = 32'h40; RS2data_i = 32'h1234;
      for (int i = 0; i < 2; i++) begin
         mem_ack_i = (i == 1);
         @(negedge clk_i);
         if (mem_req_o) begin
            nreq++;
            total++; if (mem_we_o !== 1'b1) begin bad++; $display("FAIL st_we got=%b want=1", mem_we_o); end
            total++; if (mem_wdata_o !== 32'h1234) begin bad++; $display("FAIL st_wdata got=%h want=00001234", mem_wdata_o); end
            total++; if (mem_addr_o !== 32'h40) begin bad++; $display("FAIL st_addr got=%h want=00000040", mem_addr_o); end
         end
         if (stall_o) nstall++;
         next_edge();
         total++; if (RegWrite_o !== 1'b0) begin bad++; $display("FAIL st_rw cyc=%0d got=%b want=0", i, RegWrite_o); end
      end
      total++; if (nreq != 1) begin bad++; $display("FAIL st_req_cycles got=%0d want=1", nreq); end
      total++; if (nstall != 1) begin bad++; $display("FAIL st_stall_cycles got=%0d want=1", nstall); end
      idle_inputs();
      @(negedge clk_i);
      total++; if (stall_o !== 1'b0 || mem_req_o !== 1'b0) begin bad++; $display("FAIL st_back_idle got=stall%b/req%b want=0/0", stall_o, mem_req_o); end
      next_edge();
   endtask

   task automatic test_timeout();
      int nreq = 0;
      RDaddr_i = 5'd4; RegWrite_i = 1'b1; MemRead_i = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk_i);
         if (mem_req_o) nreq++;
         total++; if (stall_o !== (i != 4)) begin bad++; $display("FAIL to_stall cyc=%0d got=%b want=%b", i, stall_o, (i != 4)); end
         total++; if (err_o !== 1'b0) begin bad++; $display("FAIL to_err_early cyc=%0d got=%b want=0", i, err_o); end
         next_edge();
         total++; if (RegWrite_o !== 1'b0) begin bad++; $display("FAIL to_rw cyc=%0d got=%b want=0", i, RegWrite_o); end
      end
      total++; if (nreq != 4) begin bad++; $display("FAIL to_req_cycles got=%0d want=4", nreq); end
      total++; if (err_o !== 1'b1) begin bad++; $display("FAIL to_err got=%b want=1", err_o); end
      // Late ack while idle: plain ALU op must not pick up rdata.
      idle_inputs();
      RDaddr_i = 5'd2; MemtoReg_i = 1'b1; ALUResult_i = 32'h77;
      mem_ack_i = 1'b1; mem_rdata_i = 32'h5555;
      @(negedge clk_i);
      total++; if (mem_req_o !== 1'b0) begin bad++; $display("FAIL to_late_req got=%b want=0", mem_req_o); end
      next_edge();
      mem_ack_i = 1'b0;
      total++; if (WBdata_o !== 32'h77) begin bad++; $display("FAIL to_late_wb got=%h want=00000077", WBdata_o); end
      total++; if (RegWrite_o !== 1'b0) begin bad++; $display("FAIL to_late_rw got=%b want=0", RegWrite_o); end
      next_edge();
      total++; if (err_o !== 1'b1) begin bad++; $display("FAIL to_err_sticky got=%b want=1", err_o); end
      idle_inputs();
   endtask

   task automatic test_reset_mid_wait();
      RDaddr_i = 5'd9; RegWrite_i = 1'b1; ALUResult_i = 32'h99;
      next_edge();
      MemRead_i = 1'b1;
      next_edge();
      @(negedge clk_i);
      total++; if (mem_req_o !== 1'b1) begin bad++; $display("FAIL rmw_in_wait got=%b want=1", mem_req_o); end
      next_edge();
      start_i = 1'b0;
      MemRead_i = 1'b0;
      @(negedge clk_i);
      total++; if (mem_req_o !== 1'b0 || stall_o !== 1'b0) begin bad++; $display("FAIL rmw_forced got=req%b/stall%b want=0/0", mem_req_o, stall_o); end
      next_edge();
      start_i = 1'b1;
      idle_inputs();
      total++; if (RDaddr_o !== 5'd0) begin bad++; $display("FAIL rmw_rd got=%0d want=0", RDaddr_o); end
      total++; if (RegWrite_o !== 1'b0) begin bad++; $display("FAIL rmw_rw got=%b want=0", RegWrite_o); end
      total++; if (WBdata_o !== 32'h0) begin bad++; $display("FAIL rmw_wb got=%h want=0", WBdata_o); end
      total++; if (err_o !== 1'b0) begin bad++; $display("FAIL rmw_err got=%b want=0", err_o); end
      @(negedge clk_i);
      total++; if (mem_req_o !== 1'b0 || stall_o !== 1'b0) begin bad++; $display("FAIL rmw_after got=req%b/stall%b want=0/0", mem_req_o, stall_o); end
      next_edge();
   endtask

   task automatic test_back_to_back();
      logic [3:0] pat;
      pat = '0;
      RDaddr_i = 5'd10; RegWrite_i = 1'b1; MemRead_i = 1'b1; MemtoReg_i = 1'b1;
      ALUResult_i = 32'h200; mem_rdata_i = 32'h1111_1111;
      for (int i = 0; i < 4; i++) begin
         if (i == 2) begin
            RDaddr_i = 5'd11; ALUResult_i = 32'h204; mem_rdata_i = 32'h2222_2222;
         end
         mem_ack_i = (i == 1 || i == 3);
         @(negedge clk_i);
         pat[3-i] = stall_o;
         next_edge();
         if (i == 0 || i == 2) begin
            total++; if (RegWrite_o !== 1'b0) begin bad++; $display("FAIL b2b_bubble cyc=%0d got=%b want=0", i, RegWrite_o); end
         end
      end
      total++; if (pat !== 4'b1010) begin bad++; $display("FAIL b2b_stall_pattern got=%b want=1010", pat); end
      total++; if (RDaddr_o !== 5'd11) begin bad++; $display("FAIL b2b_rd got=%0d want=11", RDaddr_o); end
      total++; if (RegWrite_o !== 1'b1) begin bad++; $display("FAIL b2b_rw got=%b want=1", RegWrite_o); end
      total++; if (WBdata_o !== 32'h2222_2222) begin bad++; $display("FAIL b2b_wb got=%h want=22222222", WBdata_o); end
      idle_inputs();
   endtask

   task automatic test_first_of_pair();
      // First load of a pair: result visible after its ack edge.
      RDaddr_i = 5'd12; RegWrite_i = 1'b1; MemRead_i = 1'b1; MemtoReg_i = 1'b1;
      ALUResult_i = 32'h300; mem_rdata_i = 32'h3333_3333;
      next_edge();
      mem_ack_i = 1'b1;
      next_edge();
      mem_ack_i = 1'b0;
      total++; if (RDaddr_o !== 5'd12 || WBdata_o !== 32'h3333_3333) begin bad++; $display("FAIL pair_first got=rd%0d/%h want=rd12/33333333", RDaddr_o, WBdata_o); end
      idle_inputs();
      next_edge();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_alu();
      test_load();
      test_store();
      test_timeout();
      test_reset_mid_wait();
      test_first_of_pair();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
